triangle_traversal: RTL and testbench

Bounding-box traversal stage feeding `pixel_eval`. Accepts one screen-space triangle at a time, computes its clamped integer bounding box, and streams every pixel coordinate in the box in raster order as a `pixel_state_t` over a valid/ready handshake. Sits between triangle setup and `pixel_eval`, and is the producer side of `pixel_eval`'s `in_pixel`/`in_valid`/`in_ready` interface. The inside test is left to `pixel_eval`.

---
 rtl/triangle_traversal.sv | 226 ++++++++++++++++++++++
 tb/tb_triangle_traversal.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_traversal.sv
// triangle_traversal
// -----------------------------------------------------------------------------
// Bounding-box traversal stage that sits between triangle setup and pixel_eval.
// It takes one screen-space triangle at a time and computes the integer
// bounding box of its vertices, clamped to the screen. It then streams every
// pixel coordinate inside that box in raster order. The inside test is done
// downstream.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid && ready are both high. The producer holds valid and every
// payload bit stable until that edge. The ready signal never depends
// combinationally on valid. in_ready and out_valid are decodes of the
// registered state only.
//
// Ports
//   clk        in   single clock, rising-edge
//   rst_n      in   asynchronous active-low reset
//   in_tri     in   pixel_state_t triangle; x/y fields ignored
//   in_valid   in   in_tri is valid
//   in_ready   out  idle and out of reset; a triangle can be taken
//   out_pixel  out  latched triangle with x/y = current pixel
//   out_valid  out  out_pixel is valid
//   out_ready  in   consumer accepts out_pixel
//   out_last   out  final pixel of the triangle (qualified by out_valid)
//   busy       out  a triangle is in flight
//   dbg_state  out  current FSM state encoding (for checkers)
// -----------------------------------------------------------------------------

package triangle_traversal_pkg;
  typedef logic signed [31:0] q16_16_t;
  typedef logic [11:0]        color12_t;

  typedef struct packed {
    q16_16_t x;
    q16_16_t y;
  } vec2_t;

  typedef struct packed {
    vec2_t       v0;
    vec2_t       v1;
    vec2_t       v2;
    color12_t    v0_color;
    color12_t    v1_color;
    color12_t    v2_color;
    q16_16_t     v0_depth;
    q16_16_t     v1_depth;
    q16_16_t     v2_depth;
    logic [15:0] x;
    logic [15:0] y;
  } pixel_state_t;
endpackage

module triangle_traversal
  import triangle_traversal_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic         clk,
  input  logic         rst_n,
  input  pixel_state_t in_tri,
  input  logic         in_valid,
  output logic         in_ready,
  output pixel_state_t out_pixel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  // S_BOUND floors the latched vertices and registers the raw min/max.
  // S_SETUP then runs the empty test and clamps from those registers. This
  // splits the three-way signed compare from the bound/clamp compare. It also
  // puts the first pixel two edges after acceptance.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BOUND = 2'd1,
    S_SETUP = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  localparam logic signed [31:0] X_MAX = 32'(WIDTH - 1);
  localparam logic signed [31:0] Y_MAX = 32'(HEIGHT - 1);

  // Integer part of a Q16.16 value, rounded toward minus infinity.
  function automatic logic signed [31:0] floor_q(input q16_16_t q);
    return q >>> 16;
  endfunction

  function automatic logic signed [31:0] min3(input logic signed [31:0] a,
                                              input logic signed [31:0] b,
                                              input logic signed [31:0] c);
    logic signed [31:0] m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  function automatic logic signed [31:0] max3(input logic signed [31:0] a,
                                              input logic signed [31:0] b,
                                              input logic signed [31:0] c);
    logic signed [31:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  pixel_state_t       r_tri;

  // Unclamped signed box, valid from S_SETUP onward.
  logic signed [31:0] r_bmin_x;
  logic signed [31:0] r_bmax_x;
  logic signed [31:0] r_bmin_y;
  logic signed [31:0] r_bmax_y;

  // Clamped box and raster cursor, valid in S_EMIT.
  logic [15:0]        r_min_x;
  logic [15:0]        r_max_x;
  logic [15:0]        r_max_y;
  logic [15:0]        r_cur_x;
  logic [15:0]        r_cur_y;

  logic               w_accept;
  logic               w_empty;
  logic               w_last;
  logic               w_pix_accept;
  logic [15:0]        w_lo_x;
  logic [15:0]        w_hi_x;
  logic [15:0]        w_lo_y;
  logic [15:0]        w_hi_y;

  assign w_accept     = in_valid && in_ready;
  assign w_last       = (r_cur_x == r_max_x) && (r_cur_y == r_max_y);
  assign w_pix_accept = (r_state == S_EMIT) && out_ready;

  // The empty test runs on the unclamped box. Clamping could otherwise pull
  // a fully offscreen box back onto the screen edge.
  assign w_empty = (r_bmax_x < 32'sd0) || (r_bmin_x > X_MAX) ||
                   (r_bmax_y < 32'sd0) || (r_bmin_y > Y_MAX);

  // If the box is not empty, each lower bound is <= the screen max and each
  // upper bound is >= 0. So only one side of each bound needs clamping.
  assign w_lo_x = (r_bmin_x < 32'sd0) ? 16'd0 : r_bmin_x[15:0];
  assign w_hi_x = (r_bmax_x > X_MAX)  ? X_MAX[15:0] : r_bmax_x[15:0];
  assign w_lo_y = (r_bmin_y < 32'sd0) ? 16'd0 : r_bmin_y[15:0];
  assign w_hi_y = (r_bmax_y > Y_MAX)  ? Y_MAX[15:0] : r_bmax_y[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_tri    <= '0;
      r_bmin_x <= '0;
      r_bmax_x <= '0;
      r_bmin_y <= '0;
      r_bmax_y <= '0;
      r_min_x  <= '0;
      r_max_x  <= '0;
      r_max_y  <= '0;
      r_cur_x  <= '0;
      r_cur_y  <= '0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == S_IDLE) && w_accept) begin
        r_tri <= in_tri;
      end

      if (r_state == S_BOUND) begin
        r_bmin_x <= min3(floor_q(r_tri.v0.x), floor_q(r_tri.v1.x), floor_q(r_tri.v2.x));
        r_bmax_x <= max3(floor_q(r_tri.v0.x), floor_q(r_tri.v1.x), floor_q(r_tri.v2.x));
        r_bmin_y <= min3(floor_q(r_tri.v0.y), floor_q(r_tri.v1.y), floor_q(r_tri.v2.y));
        r_bmax_y <= max3(floor_q(r_tri.v0.y), floor_q(r_tri.v1.y), floor_q(r_tri.v2.y));
      end

      if ((r_state == S_SETUP) && !w_empty) begin
        r_min_x <= w_lo_x;
        r_max_x <= w_hi_x;
        r_max_y <= w_hi_y;
        r_cur_x <= w_lo_x;
        r_cur_y <= w_lo_y;
      end

      // On the last pixel the cursor stays put. The FSM leaves EMIT, and the
      // next SETUP reloads the cursor.
      if (w_pix_accept && !w_last) begin
        if (r_cur_x < r_max_x) begin
          r_cur_x <= r_cur_x + 16'd1;
        end else begin
          r_cur_x <= r_min_x;
          r_cur_y <= r_cur_y + 16'd1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_BOUND;
      S_BOUND: w_state_nxt = S_SETUP;
      S_SETUP: w_state_nxt = w_empty ? S_IDLE : S_EMIT;
      S_EMIT:  if (out_ready && w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // rst_n gates in_ready so it reads low while reset is held. The state is
  // already IDLE at that point.
  assign in_ready  = rst_n && (r_state == S_IDLE);
  assign out_valid = (r_state == S_EMIT);
  assign out_last  = out_valid && w_last;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

  always_comb begin
    out_pixel   = r_tri;
    out_pixel.x = r_cur_x;
    out_pixel.y = r_cur_y;
  end

endmodule

// File: tb/tb_triangle_traversal.sv
module tb_triangle_traversal;
  import triangle_traversal_pkg::*;

  localparam int WIDTH  = 8;
  localparam int HEIGHT = 6;
  localparam int EW     = $bits(pixel_state_t) + 1;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  pixel_state_t in_tri;
  logic         in_valid;
  logic         in_ready;
  pixel_state_t out_pixel;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  triangle_traversal #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_tri    (in_tri),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_pixel (out_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int popped = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: stall on (3,1)
  int stall_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int qv(input int i);
    return i * 65536;
  endfunction

  function automatic int q_floor(input logic signed [31:0] q);
    int v;
    int f;
    v = q;
    f = v / 65536;
    if (v < 0 && (v % 65536) != 0) f = f - 1;
    return f;
  endfunction

  // Enumerates the clamped box in raster order and queues every pixel.
  function automatic int model_push(input pixel_state_t t);
    int xs[3];
    int ys[3];
    int lo_x, hi_x, lo_y, hi_y, n;
    pixel_state_t p;
    xs[0] = q_floor(t.v0.x); xs[1] = q_floor(t.v1.x); xs[2] = q_floor(t.v2.x);
    ys[0] = q_floor(t.v0.y); ys[1] = q_floor(t.v1.y); ys[2] = q_floor(t.v2.y);
    lo_x = xs[0]; hi_x = xs[0]; lo_y = ys[0]; hi_y = ys[0];
    for (int i = 1; i < 3; i++) begin
      if (xs[i] < lo_x) lo_x = xs[i];
      if (xs[i] > hi_x) hi_x = xs[i];
      if (ys[i] < lo_y) lo_y = ys[i];
      if (ys[i] > hi_y) hi_y = ys[i];
    end
    n = 0;
    if (hi_x < 0 || lo_x > WIDTH - 1 || hi_y < 0 || lo_y > HEIGHT - 1) return 0;
    if (lo_x < 0) lo_x = 0;
    if (hi_x > WIDTH - 1) hi_x = WIDTH - 1;
    if (lo_y < 0) lo_y = 0;
    if (hi_y > HEIGHT - 1) hi_y = HEIGHT - 1;
    for (int y = lo_y; y <= hi_y; y++) begin
      for (int x = lo_x; x <= hi_x; x++) begin
        p = t;
        p.x = 16'(x);
        p.y = 16'(y);
        exp_q.push_back({p, (x == hi_x && y == hi_y)});
        n++;
      end
    end
    pushed += n;
    return n;
  endfunction

  function automatic pixel_state_t mk_tri(input int x0, input int y0, input int x1,
                                          input int y1, input int x2, input int y2);
    pixel_state_t t;
    t.v0.x = x0; t.v0.y = y0;
    t.v1.x = x1; t.v1.y = y1;
    t.v2.x = x2; t.v2.y = y2;
    t.v0_color = 12'($urandom); t.v1_color = 12'($urandom); t.v2_color = 12'($urandom);
    t.v0_depth = $urandom; t.v1_depth = $urandom; t.v2_depth = $urandom;
    t.x = 16'($urandom);
    t.y = 16'($urandom);
    return t;
  endfunction

  function automatic pixel_state_t rand_tri();
    int c[6];
    int shift;
    shift = ($urandom_range(0, 7) == 0) ? qv(WIDTH + 1) : 0;
    for (int i = 0; i < 6; i += 2) begin
      c[i]   = int'($urandom_range(0, 14 * 65536 - 1)) - qv(3) + shift;
      c[i+1] = int'($urandom_range(0, 12 * 65536 - 1)) - qv(3);
    end
    return mk_tri(c[0], c[1], c[2], c[3], c[4], c[5]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_tri(input pixel_state_t t, output int n);
    bit got;
    int cnt;
    @(posedge clk); #1;
    in_tri = t;
    in_valid = 1'b1;
    got = 0;
    cnt = 0;
    n = 0;
    while (!got && cnt < 200) begin
      @(negedge clk);
      if (in_ready) got = 1;
      else cnt++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected 1", cnt);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    n = model_push(t);
    #1;
    in_valid = 1'b0;
    in_tri = '0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    int cnt;
    done = 0;
    cnt = 0;
    while (!done && cnt < 3000) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready && !out_valid) done = 1;
      else cnt++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: got %0d pixels outstanding, expected 0", name, exp_q.size());
    end
  endtask

  // out_ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: out_ready = ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0;
        2: begin
          if (out_valid && out_pixel.x == 16'd3 && out_pixel.y == 16'd1 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    pixel_state_t  ep;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: got x=%0d y=%0d, expected no output",
                   out_pixel.x, out_pixel.y);
        end else begin
          e = exp_q[0];
          ep = e[EW-1:1];
          if ({out_pixel, out_last} !== e) begin
            errors++;
            $display("FAIL pixel: got x=%0d y=%0d last=%0b data=%h, expected x=%0d y=%0d last=%0b data=%h",
                     out_pixel.x, out_pixel.y, out_last, out_pixel, ep.x, ep.y, e[0], ep);
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    pixel_state_t t;
    pixel_state_t t2;
    int n;
    int p0;

    in_valid = 1'b0;
    in_tri = '0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_state", dbg_state, 0);
    check("reset_out_pixel_zero", (out_pixel === '0), 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);

    // basic raster order and latency
    p0 = popped;
    send_tri(mk_tri(qv(2), qv(1), qv(5), qv(1), qv(2), qv(4)), n);
    @(negedge clk);
    check("basic_in_ready_low", in_ready, 0);
    check("basic_busy", busy, 1);
    @(negedge clk);
    check("basic_no_early_valid", out_valid, 0);
    @(negedge clk);
    check("basic_first_valid", out_valid, 1);
    wait_idle("basic");
    check("basic_count", popped - p0, 16);

    // backpressure on (3,1)
    p0 = popped;
    rdy_mode = 2;
    stall_left = 3;
    send_tri(mk_tri(qv(2), qv(1), qv(5), qv(1), qv(2), qv(4)), n);
    wait_idle("backpressure");
    check("bp_stall_applied", stall_left, 0);
    check("bp_count", popped - p0, 16);
    rdy_mode = 0;

    // clamping
    p0 = popped;
    send_tri(mk_tri(-229376, qv(-2), qv(10), 0, 0, qv(10)), n);
    wait_idle("clamp");
    check("clamp_count", popped - p0, 48);

    // offscreen
    p0 = popped;
    send_tri(mk_tri(qv(WIDTH), qv(1), qv(WIDTH + 1) + 100, qv(3), qv(12), 0), n);
    @(negedge clk);
    check("offscreen_in_ready_k", in_ready, 0);
    @(negedge clk);
    check("offscreen_in_ready_k1", in_ready, 0);
    @(negedge clk);
    check("offscreen_in_ready_k2", in_ready, 1);
    check("offscreen_busy", busy, 0);
    wait_idle("offscreen");
    check("offscreen_count", popped - p0, 0);

    // single point, then a back-to-back triangle
    p0 = popped;
    send_tri(mk_tri(qv(3) + 16384, qv(2) + 49152, qv(3) + 16384, qv(2) + 49152,
                    qv(3) + 16384, qv(2) + 49152), n);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("single_valid", out_valid, 1);
    check("single_last", out_last, 1);
    check("single_in_ready_busy", in_ready, 0);
    t2 = mk_tri(qv(0), qv(0), qv(1), qv(0), qv(0), qv(1));
    in_tri = t2;
    in_valid = 1'b1;
    @(negedge clk);
    check("single_next_ready", in_ready, 1);
    @(posedge clk);
    n = model_push(t2);
    #1;
    in_valid = 1'b0;
    in_tri = '0;
    wait_idle("single");
    check("single_count", popped - p0, 1 + 4);

    // reset in the middle of emission
    send_tri(mk_tri(-229376, qv(-2), qv(10), 0, 0, qv(10)), n);
    repeat (6) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_out_last", out_last, 0);
    check("midreset_busy", busy, 0);
    check("midreset_in_ready", in_ready, 0);
    pushed -= exp_q.size();
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("midreset_held_valid", out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_release_ready", in_ready, 1);
    check("midreset_release_valid", out_valid, 0);
    p0 = popped;
    send_tri(mk_tri(qv(1), qv(2), qv(4), qv(3), qv(2), qv(5)), n);
    wait_idle("after_reset");
    check("after_reset_count", popped - p0, 16);

    // randomized triangles with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      t = rand_tri();
      send_tri(t, n);
    end
    wait_idle("random");
    rdy_mode = 0;

    check("total_pixels", popped, pushed);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
